// File: rtl/sha3_digest_axis_tx_if.sv
// ============================================================================
//  Module   : sha3_digest_axis_tx_if
//  Purpose  : Core-side capture handshake and AXI4-Stream digest bus.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface sha3_digest_axis_tx_if #(
    parameter int DATA_WIDTH = 16
);
    localparam int KEEP_WIDTH = DATA_WIDTH / 8;

    logic                  s_valid;
    logic                  s_ready;
    logic [1599:0]         s_state;
    logic [2:0]            s_tuser;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic [KEEP_WIDTH-1:0] m_axis_tkeep;
    logic                  m_axis_tlast;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;

    // master: the digest transmitter itself
    modport master (
        input  s_valid, s_state, s_tuser, m_axis_tready,
        output s_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );

    // slave: the permutation core plus the downstream stream sink
    modport slave (
        output s_valid, s_state, s_tuser, m_axis_tready,
        input  s_ready, m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid
    );
endinterface

`default_nettype wire

// File: rtl/sha3_digest_axis_tx.sv
// ============================================================================
//  Module   : sha3_digest_axis_tx
//  Purpose  : Captures a Keccak-f[1600] state and streams the mode's digest
//             as AXI4-Stream beats with TLAST and a partial-beat TKEEP.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sha3_digest_axis_tx #(
    parameter int DATA_WIDTH = 16,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
    input  logic                       ACLK,
    input  logic                       ARESETn,
    sha3_digest_axis_tx_if.master      bus,
    output logic                       busy
);

    localparam int c_LOG2W = $clog2(DATA_WIDTH);

    generate
        if (!((DATA_WIDTH == 8) || (DATA_WIDTH == 16) || (DATA_WIDTH == 32) ||
              (DATA_WIDTH == 64)) || (KEEP_WIDTH != DATA_WIDTH / 8)) begin : g_bad_width
            $error("sha3_digest_axis_tx: DATA_WIDTH must be 8/16/32/64 and KEEP_WIDTH = DATA_WIDTH/8");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [7:0]            r_beat_cnt;
    logic [7:0]            r_last_idx;
    logic [KEEP_WIDTH-1:0] r_keep_last;
    logic [1599:0]         r_shreg;

    logic [10:0]           w_len;
    logic [7:0]            w_last_idx;
    logic [10:0]           w_rem;
    logic [KEEP_WIDTH-1:0] w_keep_last;
    logic                  w_capture;
    logic                  w_beat;
    logic                  w_last;
    logic                  w_s_ready;
    logic                  w_tvalid;
    logic                  w_tlast;
    logic [KEEP_WIDTH-1:0] w_tkeep;
    logic [DATA_WIDTH-1:0] w_tdata;

    // Digest length in bits for the requested mode; reserved codes fall back to 256.
    always_comb begin
        w_len = 11'd256;
        case (bus.s_tuser)
            3'd0:    w_len = 11'd224;
            3'd1:    w_len = 11'd256;
            3'd2:    w_len = 11'd384;
            3'd3:    w_len = 11'd512;
            3'd4:    w_len = 11'd1600;
            default: w_len = 11'd256;
        endcase
    end

    // Index of the final beat and the bits left over for it (always a whole number of bytes).
    assign w_last_idx = 8'(((12'(w_len) + 12'(DATA_WIDTH - 1)) >> c_LOG2W) - 12'd1);
    assign w_rem      = w_len - (11'(w_last_idx) << c_LOG2W);

    always_comb begin
        w_keep_last = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_keep_last[i] = (11'(8 * i) < w_rem);
        end
    end

    assign w_capture = (r_state == ST_IDLE) && bus.s_valid;
    assign w_beat    = (r_state == ST_STREAM) && bus.m_axis_tready;
    assign w_last    = (r_beat_cnt == r_last_idx);

    always_comb begin
        w_state_next = r_state;
        w_s_ready    = 1'b0;
        busy         = 1'b0;
        w_tvalid     = 1'b0;
        w_tlast      = 1'b0;
        w_tkeep      = '0;
        case (r_state)
            ST_IDLE: begin
                w_s_ready = 1'b1;
                if (bus.s_valid) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                busy     = 1'b1;
                w_tvalid = 1'b1;
                w_tlast  = w_last;
                w_tkeep  = w_last ? r_keep_last : '1;
                if (bus.m_axis_tready && w_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Bytes outside TKEEP are forced to zero, which also zeroes TDATA whenever idle.
    always_comb begin
        w_tdata = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            w_tdata[8*i +: 8] = w_tkeep[i] ? r_shreg[8*i +: 8] : 8'h00;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state     <= ST_IDLE;
            r_beat_cnt  <= 8'd0;
            r_last_idx  <= 8'd0;
            r_keep_last <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_beat_cnt  <= 8'd0;
                r_last_idx  <= w_last_idx;
                r_keep_last <= w_keep_last;
            end else if (w_beat) begin
                r_beat_cnt <= r_beat_cnt + 8'd1;
            end
        end
    end

    // The state register carries no reset: its contents never reach TDATA while idle.
    always_ff @(posedge ACLK) begin
        if (w_capture) begin
            r_shreg <= bus.s_state;
        end else if (w_beat) begin
            r_shreg <= r_shreg >> DATA_WIDTH;
        end
    end

    assign bus.s_ready       = w_s_ready;
    assign bus.m_axis_tvalid = w_tvalid;
    assign bus.m_axis_tlast  = w_tlast;
    assign bus.m_axis_tkeep  = w_tkeep;
    assign bus.m_axis_tdata  = w_tdata;

endmodule

`default_nettype wire

// File: tb/tb_sha3_digest_axis_tx.sv
// ============================================================================
//  Module   : tb_sha3_digest_axis_tx
//  Purpose  : Self-checking bench for the digest transmitter at 16/32/64-bit
//             beat widths against a byte-level digest model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sha3_digest_axis_tx;

    localparam int NINST = 3;

    logic          clk = 1'b0;
    logic          arst_n;
    logic          sv [NINST];
    logic [1599:0] st;
    logic [2:0]    tu;
    logic          trdy;

    logic          sr [NINST];
    logic          tv [NINST];
    logic          tl [NINST];
    logic          bz [NINST];
    logic [63:0]   td [NINST];
    logic [7:0]    tk [NINST];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NINST; g++) begin : g_dut
            localparam int W = 16 << g;
            sha3_digest_axis_tx_if #(.DATA_WIDTH(W)) bus ();

            assign bus.s_valid       = sv[g];
            assign bus.s_state       = st;
            assign bus.s_tuser       = tu;
            assign bus.m_axis_tready = trdy;
            assign sr[g] = bus.s_ready;
            assign tv[g] = bus.m_axis_tvalid;
            assign tl[g] = bus.m_axis_tlast;
            assign td[g] = 64'(bus.m_axis_tdata);
            assign tk[g] = 8'(bus.m_axis_tkeep);

            sha3_digest_axis_tx #(.DATA_WIDTH(W)) u_dut (
                .ACLK    (clk),
                .ARESETn (arst_n),
                .bus     (bus.master),
                .busy    (bz[g])
            );
        end
    endgenerate

    function automatic int w_of(input int sel);
        return 16 << sel;
    endfunction

    function automatic int len_bytes(input logic [2:0] m);
        case (m)
            3'd0:    return 28;
            3'd2:    return 48;
            3'd3:    return 64;
            3'd4:    return 200;
            default: return 32;
        endcase
    endfunction

    function automatic int model_nbeats(input logic [2:0] m, input int w);
        int bpb;
        bpb = w / 8;
        return (len_bytes(m) + bpb - 1) / bpb;
    endfunction

    // Digest = first len_bytes(m) bytes of the state, byte j at bits [8j+:8], packed bpb per beat.
    task automatic model_beat(input logic [1599:0] s, input logic [2:0] m, input int w, input int k,
                              output logic [63:0] d, output logic [7:0] kp, output logic lst);
        int bpb;
        int j;
        bpb = w / 8;
        d   = '0;
        kp  = '0;
        for (int b = 0; b < bpb; b++) begin
            j = k * bpb + b;
            if (j < len_bytes(m)) begin
                kp[b]      = 1'b1;
                d[8*b +: 8] = s[8*j +: 8];
            end
        end
        lst = (k == model_nbeats(m, w) - 1);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    function automatic logic [1599:0] rand_state();
        logic [1599:0] s;
        for (int i = 0; i < 50; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic check_idle_outputs(input int sel, input string tag);
        check({tag, " s_ready"}, 64'(sr[sel]), 64'd1);
        check({tag, " tvalid"},  64'(tv[sel]), 64'd0);
        check({tag, " tlast"},   64'(tl[sel]), 64'd0);
        check({tag, " busy"},    64'(bz[sel]), 64'd0);
    endtask

    // Entered and left just after a falling edge; outputs are sampled on falling edges.
    task automatic run_frame(input int sel, input logic [2:0] mode, input logic [1599:0] s,
                             input bit stall, input bit hold, input logic [1599:0] s_next,
                             input logic [2:0] m_next, input int abort_at,
                             output int nb, output logic [7:0] kfinal);
        int          guard;
        int          nmodel;
        bit          got_last;
        bit          prev_stall;
        logic [63:0] pd, ed;
        logic [7:0]  pk, ek;
        logic        pl, el, rdy;
        nb = 0; kfinal = '0; guard = 0; got_last = 0; prev_stall = 0;
        pd = '0; pk = '0; pl = 1'b0;
        nmodel = model_nbeats(mode, w_of(sel));
        while (!sr[sel] && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("s_ready before capture", 64'(sr[sel]), 64'd1);
        sv[sel] = 1'b1; st = s; tu = mode; trdy = 1'b0;
        @(negedge clk);
        check("tvalid one cycle after capture", 64'(tv[sel]), 64'd1);
        check("s_ready low while streaming", 64'(sr[sel]), 64'd0);
        check("busy while streaming", 64'(bz[sel]), 64'd1);
        if (hold) begin
            st = s_next;
            tu = m_next;
        end else begin
            sv[sel] = 1'b0;
        end
        guard = 0;
        while (!got_last && nb <= nmodel && guard < 2000) begin
            if (abort_at > 0 && nb == abort_at) return;
            if (prev_stall) begin
                check("tdata stable while stalled", td[sel], pd);
                check("tkeep stable while stalled", 64'(tk[sel]), 64'(pk));
                check("tlast stable while stalled", 64'(tl[sel]), 64'(pl));
            end
            check("tvalid held until transfer", 64'(tv[sel]), 64'd1);
            rdy  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            trdy = rdy;
            if (rdy) begin
                model_beat(s, mode, w_of(sel), nb, ed, ek, el);
                check($sformatf("beat %0d tdata", nb), td[sel], ed);
                check($sformatf("beat %0d tkeep", nb), 64'(tk[sel]), 64'(ek));
                check($sformatf("beat %0d tlast", nb), 64'(tl[sel]), 64'(el));
                if (tl[sel]) begin
                    got_last = 1'b1;
                    kfinal   = tk[sel];
                end
                nb++;
            end
            prev_stall = !rdy;
            pd = td[sel]; pk = tk[sel]; pl = tl[sel];
            if (!got_last) @(negedge clk);
            guard++;
        end
        check("frame ended by a tlast transfer", 64'(got_last), 64'd1);
        @(negedge clk);
        trdy = 1'b0;
        check_idle_outputs(sel, "after final beat");
    endtask

    typedef struct {
        int         sel;
        logic [2:0] mode;
        bit         stall;
        int         exp_n;
        logic [7:0] exp_keep;
    } vec_t;

    vec_t vt [12];

    initial begin
        int            nb;
        int            sel;
        logic [7:0]    kf;
        logic [2:0]    mode;
        logic [1599:0] s1, s2;
        logic [63:0]   ed;
        logic [7:0]    ek;
        logic          el;

        vt[0]  = '{0, 3'd1, 1'b0, 16,  8'h03};
        vt[1]  = '{2, 3'd0, 1'b0, 4,   8'h0F};
        vt[2]  = '{2, 3'd4, 1'b0, 25,  8'hFF};
        vt[3]  = '{1, 3'd3, 1'b1, 16,  8'h0F};
        vt[4]  = '{0, 3'd0, 1'b1, 14,  8'h03};
        vt[5]  = '{1, 3'd2, 1'b0, 12,  8'h0F};
        vt[6]  = '{2, 3'd2, 1'b1, 6,   8'hFF};
        vt[7]  = '{1, 3'd0, 1'b1, 7,   8'h0F};
        vt[8]  = '{0, 3'd4, 1'b1, 100, 8'h03};
        vt[9]  = '{1, 3'd7, 1'b0, 8,   8'h0F};
        vt[10] = '{2, 3'd5, 1'b1, 4,   8'hFF};
        vt[11] = '{2, 3'd3, 1'b0, 8,   8'hFF};

        for (int i = 0; i < NINST; i++) sv[i] = 1'b0;
        st = '0; tu = '0; trdy = 1'b0; arst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < NINST; i++) begin
            check_idle_outputs(i, "reset");
            check("reset tkeep", 64'(tk[i]), 64'd0);
            check("reset tdata", td[i], 64'd0);
        end
        arst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            s1 = rand_state();
            run_frame(vt[i].sel, vt[i].mode, s1, vt[i].stall, 1'b0, '0, 3'd0, 0, nb, kf);
            check($sformatf("vector %0d beat count", i), 64'(nb), 64'(vt[i].exp_n));
            check($sformatf("vector %0d final tkeep", i), 64'(kf), 64'(vt[i].exp_keep));
        end

        // Asynchronous reset while beat 5 of a SHA3-384 frame is on the bus.
        s1 = rand_state();
        run_frame(1, 3'd2, s1, 1'b0, 1'b0, '0, 3'd0, 5, nb, kf);
        check("abort point beat count", 64'(nb), 64'd5);
        check("beat 5 presented before reset", 64'(tv[1]), 64'd1);
        #2 arst_n = 1'b0;
        #1;
        check_idle_outputs(1, "mid-frame reset");
        check("mid-frame reset tkeep", 64'(tk[1]), 64'd0);
        check("mid-frame reset tdata", td[1], 64'd0);
        @(negedge clk);
        arst_n = 1'b1;
        trdy   = 1'b0;
        s2 = rand_state();
        run_frame(1, 3'd2, s2, 1'b0, 1'b0, '0, 3'd0, 0, nb, kf);
        check("frame after reset beat count", 64'(nb), 64'd12);
        check("frame after reset final tkeep", 64'(kf), 64'h0F);

        // s_valid held through a frame with a different state: captured only after tlast.
        s1 = rand_state();
        s2 = rand_state();
        run_frame(2, 3'd3, s1, 1'b0, 1'b1, s2, 3'd6, 0, nb, kf);
        check("held-valid first frame beat count", 64'(nb), 64'd8);
        run_frame(2, 3'd6, s2, 1'b0, 1'b0, '0, 3'd0, 0, nb, kf);
        check("tuser 6 beat count", 64'(nb), 64'd4);
        check("tuser 6 final tkeep", 64'(kf), 64'hFF);

        repeat (10) begin
            sel  = int'($urandom_range(0, 2));
            mode = 3'($urandom_range(0, 7));
            s1   = rand_state();
            run_frame(sel, mode, s1, 1'($urandom_range(0, 1)), 1'b0, '0, 3'd0, 0, nb, kf);
            check("random frame beat count", 64'(nb), 64'(model_nbeats(mode, w_of(sel))));
            model_beat(s1, mode, w_of(sel), model_nbeats(mode, w_of(sel)) - 1, ed, ek, el);
            check("random frame final tkeep", 64'(kf), 64'(ek));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
